// File: rtl/fir_ctrl_sequencer_if.sv
// Purpose : bundles the shared input bus and the FIR-facing outputs of fir_ctrl_sequencer.
// Latency : none (wires only).
// Backpr. : none; the producer may drive in_valid every cycle, the sequencer drops what it cannot use.
//
// Signals:
//   in_data        shared byte bus, carries a coefficient or a sample
//   in_valid       in_data is meaningful this cycle
//   in_set_coeffs  1 = in_data is a coefficient, 0 = in_data is a sample
//   coeff_wr_*     coefficient register write port towards the FIR
//   sample_*       sample push towards the FIR
//   busy           sequencer is loading coefficients or flushing the delay line
//   load_done      one-cycle pulse when a full coefficient set has been written
//   err_short      sticky, last load was cut short
//   drop_cnt       saturating count of discarded inputs
//   state_o        current sequencer state (IDLE=0, LOAD=1, FLUSH=2, RUN=3)
//
// Modports: master = source of the input bus / sink of the outputs,
//           slave  = the sequencer itself.
interface fir_ctrl_sequencer_if #(
    parameter int NTAPS = 4,
    parameter int DW    = 8
);
    localparam int AW = $clog2(NTAPS);

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_set_coeffs;

    logic          coeff_wr_en;
    logic [AW-1:0] coeff_wr_addr;
    logic [DW-1:0] coeff_wr_data;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          busy;
    logic          load_done;
    logic          err_short;
    logic [7:0]    drop_cnt;
    logic [1:0]    state_o;

    modport master (
        output in_data,
        output in_valid,
        output in_set_coeffs,
        input  coeff_wr_en,
        input  coeff_wr_addr,
        input  coeff_wr_data,
        input  sample_valid,
        input  sample_data,
        input  busy,
        input  load_done,
        input  err_short,
        input  drop_cnt,
        input  state_o
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_set_coeffs,
        output coeff_wr_en,
        output coeff_wr_addr,
        output coeff_wr_data,
        output sample_valid,
        output sample_data,
        output busy,
        output load_done,
        output err_short,
        output drop_cnt,
        output state_o
    );
endinterface

// File: rtl/fir_ctrl_sequencer.sv
// Purpose : steers the shared byte bus into FIR coefficient writes or sample pushes, zero-flushes after each load.
// Latency : 1 cycle, every output is registered.
// Backpr. : none; inputs that cannot be used (IDLE samples, anything during FLUSH) are dropped and counted.
//
// Ports:
//   clk    rising-edge clock for all logic
//   reset  synchronous, active-high; returns to IDLE with all outputs cleared
//   bus    fir_ctrl_sequencer_if.slave, see the interface for the signal list
//
// State machine:
//   IDLE  : no coefficient set yet; samples are discarded.
//   LOAD  : coefficient bytes written to addresses 0..NTAPS-1; in_valid low stalls,
//           in_set_coeffs low aborts (err_short) and still flushes.
//   FLUSH : NTAPS zero samples pushed so the delay line holds no stale data.
//   RUN   : samples forwarded to the FIR; in_set_coeffs starts a new load.
module fir_ctrl_sequencer #(
    parameter int NTAPS = 4,
    parameter int DW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    fir_ctrl_sequencer_if.slave   bus
);

    localparam int AW = $clog2(NTAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t        state_q,         state_d;
    logic [AW-1:0] idx_q,           idx_d;
    logic [AW-1:0] flush_cnt_q,     flush_cnt_d;

    logic          coeff_wr_en_q,   coeff_wr_en_d;
    logic [AW-1:0] coeff_wr_addr_q, coeff_wr_addr_d;
    logic [DW-1:0] coeff_wr_data_q, coeff_wr_data_d;
    logic          sample_valid_q,  sample_valid_d;
    logic [DW-1:0] sample_data_q,   sample_data_d;
    logic          load_done_q,     load_done_d;
    logic          err_short_q,     err_short_d;
    logic [7:0]    drop_cnt_q,      drop_cnt_d;
    logic          drop_inc;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        flush_cnt_d     = flush_cnt_q;
        coeff_wr_en_d   = 1'b0;
        coeff_wr_addr_d = coeff_wr_addr_q;
        coeff_wr_data_d = coeff_wr_data_q;
        sample_valid_d  = 1'b0;
        sample_data_d   = sample_data_q;
        load_done_d     = 1'b0;
        err_short_d     = err_short_q;
        drop_inc        = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.in_set_coeffs) begin
                    // Start of a load. A byte arriving together with the mode
                    // switch is the coefficient for address 0.
                    state_d = ST_LOAD;
                    if (bus.in_valid) begin
                        coeff_wr_en_d   = 1'b1;
                        coeff_wr_addr_d = '0;
                        coeff_wr_data_d = bus.in_data;
                        idx_d           = AW'(1);
                    end else begin
                        idx_d           = '0;
                    end
                end else if (bus.in_valid) begin
                    if (state_q == ST_RUN) begin
                        sample_valid_d = 1'b1;
                        sample_data_d  = bus.in_data;
                    end else begin
                        // No coefficient set yet: the FIR must not see samples.
                        drop_inc = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (bus.in_set_coeffs) begin
                    // in_valid low here is a stall: idx and state are held.
                    if (bus.in_valid) begin
                        coeff_wr_en_d   = 1'b1;
                        coeff_wr_addr_d = idx_q;
                        coeff_wr_data_d = bus.in_data;
                        if (idx_q == LAST_IDX) begin
                            load_done_d = 1'b1;
                            err_short_d = 1'b0;
                            idx_d       = '0;
                            flush_cnt_d = '0;
                            state_d     = ST_FLUSH;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end
                end else begin
                    // Load cut short. Whatever was written stays in the FIR;
                    // the delay line is still flushed so RUN starts clean.
                    // A sample arriving on the abort cycle has nowhere to go.
                    err_short_d = 1'b1;
                    idx_d       = '0;
                    flush_cnt_d = '0;
                    state_d     = ST_FLUSH;
                    drop_inc    = bus.in_valid;
                end
            end

            ST_FLUSH: begin
                sample_valid_d = 1'b1;
                sample_data_d  = '0;
                // Anything presented while flushing is lost, coefficients included.
                drop_inc       = bus.in_valid;
                if (flush_cnt_q == LAST_IDX) begin
                    flush_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + AW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Saturating drop counter, cleared only by reset.
        if (drop_inc && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            flush_cnt_q     <= '0;
            coeff_wr_en_q   <= 1'b0;
            coeff_wr_addr_q <= '0;
            coeff_wr_data_q <= '0;
            sample_valid_q  <= 1'b0;
            sample_data_q   <= '0;
            load_done_q     <= 1'b0;
            err_short_q     <= 1'b0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            flush_cnt_q     <= flush_cnt_d;
            coeff_wr_en_q   <= coeff_wr_en_d;
            coeff_wr_addr_q <= coeff_wr_addr_d;
            coeff_wr_data_q <= coeff_wr_data_d;
            sample_valid_q  <= sample_valid_d;
            sample_data_q   <= sample_data_d;
            load_done_q     <= load_done_d;
            err_short_q     <= err_short_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.coeff_wr_en   = coeff_wr_en_q;
    assign bus.coeff_wr_addr = coeff_wr_addr_q;
    assign bus.coeff_wr_data = coeff_wr_data_q;
    assign bus.sample_valid  = sample_valid_q;
    assign bus.sample_data   = sample_data_q;
    assign bus.load_done     = load_done_q;
    assign bus.err_short     = err_short_q;
    assign bus.drop_cnt      = drop_cnt_q;
    assign bus.state_o       = state_q;
    assign bus.busy          = (state_q == ST_LOAD) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// Purpose : self-checking bench for fir_ctrl_sequencer with a table of directed vectors.
// Latency : each vector is applied before a rising edge and checked 1 time unit after it.
// Backpr. : not applicable.
module tb_fir_ctrl_sequencer;

    logic clk;
    logic reset;

    fir_ctrl_sequencer_if #(.NTAPS(4), .DW(8)) bus ();

    fir_ctrl_sequencer #(.NTAPS(4), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       vld;
        logic       set;
        logic [7:0] dat;
        logic       e_wr;
        logic [1:0] e_addr;
        logic [7:0] e_wdat;
        logic       e_sv;
        logic [7:0] e_sd;
        logic       e_busy;
        logic       e_ld;
        logic       e_err;
        logic [7:0] e_drop;
        logic [1:0] e_st;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(input logic rst, input logic vld, input logic set, input logic [7:0] dat,
                                input logic wr, input logic [1:0] addr, input logic [7:0] wdat,
                                input logic sv, input logic [7:0] sd, input logic busy,
                                input logic ld, input logic err, input logic [7:0] drop,
                                input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.vld = vld; v.set = set; v.dat = dat;
        v.e_wr = wr; v.e_addr = addr; v.e_wdat = wdat;
        v.e_sv = sv; v.e_sd = sd; v.e_busy = busy;
        v.e_ld = ld; v.e_err = err; v.e_drop = drop; v.e_st = st;
        tbl.push_back(v);
    endfunction

    // Drive one cycle of inputs, let the edge happen, then sample.
    task automatic step(input logic rst, input logic vld, input logic set, input logic [7:0] dat);
        reset             = rst;
        bus.in_valid      = vld;
        bus.in_set_coeffs = set;
        bus.in_data       = dat;
        @(posedge clk);
        #1;
    endtask

    // Address/data fields are only meaningful when their strobe is expected
    // high, except right after reset where everything must be zero.
    task automatic check(input string name, input int idx, input vec_t v);
        logic ok;
        ok = (bus.coeff_wr_en == v.e_wr) && (bus.sample_valid == v.e_sv) &&
             (bus.busy == v.e_busy) && (bus.load_done == v.e_ld) &&
             (bus.err_short == v.e_err) && (bus.drop_cnt == v.e_drop) &&
             (bus.state_o == v.e_st);
        if (v.e_wr || v.rst)
            ok = ok && (bus.coeff_wr_addr == v.e_addr) && (bus.coeff_wr_data == v.e_wdat);
        if (v.e_sv || v.rst)
            ok = ok && (bus.sample_data == v.e_sd);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s #%0d: got wr=%b a=%0d d=%h sv=%b sd=%h busy=%b ld=%b err=%b drop=%0d st=%0d | want wr=%b a=%0d d=%h sv=%b sd=%h busy=%b ld=%b err=%b drop=%0d st=%0d",
                     name, idx,
                     bus.coeff_wr_en, bus.coeff_wr_addr, bus.coeff_wr_data, bus.sample_valid, bus.sample_data,
                     bus.busy, bus.load_done, bus.err_short, bus.drop_cnt, bus.state_o,
                     v.e_wr, v.e_addr, v.e_wdat, v.e_sv, v.e_sd, v.e_busy, v.e_ld, v.e_err, v.e_drop, v.e_st);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_set_coeffs = 1'b0;
        bus.in_data       = 8'h00;

        //   rst vld set dat     wr a  wdat   sv sd     bsy ld err drop st
        // Reset, full load 11..44, flush, run samples
        add(1, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0);
        add(0, 1, 1, 8'h11,   1, 0, 8'h11, 0, 8'h00, 1, 0, 0, 8'd0, 1);
        add(0, 1, 1, 8'h22,   1, 1, 8'h22, 0, 8'h00, 1, 0, 0, 8'd0, 1);
        add(0, 1, 1, 8'h33,   1, 2, 8'h33, 0, 8'h00, 1, 0, 0, 8'd0, 1);
        add(0, 1, 1, 8'h44,   1, 3, 8'h44, 0, 8'h00, 1, 1, 0, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'd0, 3);
        add(0, 1, 0, 8'h05,   0, 0, 8'h00, 1, 8'h05, 0, 0, 0, 8'd0, 3);
        add(0, 1, 0, 8'h80,   0, 0, 8'h00, 1, 8'h80, 0, 0, 0, 8'd0, 3);
        add(0, 1, 0, 8'hFF,   0, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'd0, 3);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 3);
        // Short load from RUN: two bytes then abort, flush, RUN
        add(0, 1, 1, 8'hA1,   1, 0, 8'hA1, 0, 8'h00, 1, 0, 0, 8'd0, 1);
        add(0, 1, 1, 8'hA2,   1, 1, 8'hA2, 0, 8'h00, 1, 0, 0, 8'd0, 1);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 1, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 1, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 1, 8'd0, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'd0, 3);
        // Full load with stalls (valid 1,0,0,1,1,1) clears err_short
        add(0, 1, 1, 8'hB0,   1, 0, 8'hB0, 0, 8'h00, 1, 0, 1, 8'd0, 1);
        add(0, 0, 1, 8'h00,   0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 8'd0, 1);
        add(0, 0, 1, 8'h00,   0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 8'd0, 1);
        add(0, 1, 1, 8'hB1,   1, 1, 8'hB1, 0, 8'h00, 1, 0, 1, 8'd0, 1);
        add(0, 1, 1, 8'hB2,   1, 2, 8'hB2, 0, 8'h00, 1, 0, 1, 8'd0, 1);
        add(0, 1, 1, 8'hB3,   1, 3, 8'hB3, 0, 8'h00, 1, 1, 0, 8'd0, 2);
        // Flush with a sample and a coefficient byte presented: both dropped
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'd0, 2);
        add(0, 1, 0, 8'h77,   0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'd1, 2);
        add(0, 1, 1, 8'h66,   0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'd2, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'd2, 3);
        // RUN -> LOAD without a first byte, then first byte lands at addr 0
        add(0, 0, 1, 8'h00,   0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 8'd2, 1);
        add(0, 1, 1, 8'hC0,   1, 0, 8'hC0, 0, 8'h00, 1, 0, 0, 8'd2, 1);
        // Reset mid-LOAD
        add(1, 0, 1, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0);
        // Samples in IDLE are dropped
        add(0, 1, 0, 8'h01,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd1, 0);
        add(0, 1, 0, 8'h02,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd2, 0);
        add(0, 1, 0, 8'h03,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd3, 0);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd3, 0);
        // Load from IDLE, reset on the second FLUSH cycle
        add(0, 0, 1, 8'h00,   0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 8'd3, 1);
        add(0, 1, 1, 8'h10,   1, 0, 8'h10, 0, 8'h00, 1, 0, 0, 8'd3, 1);
        add(0, 1, 1, 8'h20,   1, 1, 8'h20, 0, 8'h00, 1, 0, 0, 8'd3, 1);
        add(0, 1, 1, 8'h30,   1, 2, 8'h30, 0, 8'h00, 1, 0, 0, 8'd3, 1);
        add(0, 1, 1, 8'h40,   1, 3, 8'h40, 0, 8'h00, 1, 1, 0, 8'd3, 2);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 8'd3, 2);
        add(1, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0);
        // Reset together with a coefficient byte: reset wins
        add(1, 1, 1, 8'hEE,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0);
        add(0, 0, 0, 8'h00,   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].set, tbl[i].dat);
            check("vec", i, tbl[i]);
        end

        // drop_cnt saturation: 300 samples in IDLE, checked at 254, 255 and 300.
        begin
            vec_t v;
            v = '{rst:1'b0, vld:1'b1, set:1'b0, dat:8'h5A, e_wr:1'b0, e_addr:2'd0, e_wdat:8'h00,
                  e_sv:1'b0, e_sd:8'h00, e_busy:1'b0, e_ld:1'b0, e_err:1'b0, e_drop:8'd0, e_st:2'd0};
            for (int n = 1; n <= 300; n++) begin
                step(1'b0, 1'b1, 1'b0, 8'h5A);
                if (n == 254 || n == 255 || n == 300) begin
                    v.e_drop = (n >= 255) ? 8'd255 : 8'(n);
                    check("drop_sat", n, v);
                end
            end
            // After saturation a reset must clear the counter.
            step(1'b1, 1'b0, 1'b0, 8'h00);
            v.rst    = 1'b1;
            v.e_drop = 8'd0;
            check("drop_clr", 0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
